regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 25 ++
 rtl/wb_skid_fifo.sv | 59 +++++
 rtl/regfile_wb_arbiter.sv | 95 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared core constants and writeback request type
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int XLEN         = 32;
    localparam int NUM_REGS     = 32;
    localparam int FIFO_DEPTH   = 2;
    localparam int STARVE_CNT_W = 4;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // One-hot register select; x0 is hardwired so it never reports busy.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] mask;
        mask = '0;
        if (addr != '0) begin
            mask[addr] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// rtl/wb_skid_fifo.sv - two-entry buffer for secondary writeback requests
module wb_skid_fifo
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   push,
    input  wb_req_t                                push_req,
    input  logic                                   pop,
    output logic [1:0]                             count,
    output wb_req_t                                head,
    output logic [FIFO_DEPTH-1:0]                  entry_valid,
    output logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0]  entry_addr
);

    wb_req_t mem [FIFO_DEPTH];
    logic    wr_ptr;
    logic    rd_ptr;

    // Pointers and occupancy; push at full and pop at empty are prevented by the caller.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Payload storage needs no reset; validity comes from count and rd_ptr.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= push_req;
        end
    end

    // Slot occupancy: full means both slots, one entry means the slot under rd_ptr.
    always_comb begin
        entry_valid = '0;
        if (count == 2'd2) begin
            entry_valid = '1;
        end else if (count == 2'd1) begin
            entry_valid[rd_ptr] = 1'b1;
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            entry_addr[i] = mem[i].addr;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write port arbiter, optional WB_STARVE_GUARD_EN
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p_wr_en,
    input  logic [REG_ADDR_W-1:0] p_wr_addr,
    input  logic [XLEN-1:0]       p_wr_data,
    input  logic                  s_valid,
    input  logic [REG_ADDR_W-1:0] s_addr,
    input  logic [XLEN-1:0]       s_data,
    output logic                  s_ready,
    output logic                  wr_en,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic [XLEN-1:0]       wr_data,
    output logic                  p_stall,
    output logic [NUM_REGS-1:0]   busy_mask
);

    logic [1:0]                            fifo_count;
    wb_req_t                               head;
    logic [FIFO_DEPTH-1:0]                 entry_valid;
    logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] entry_addr;
    logic                                  push;
    logic                                  head_grant;
    logic                                  force_grant;
    logic                                  fifo_nonempty;

    assign fifo_nonempty = (fifo_count != 2'd0);
    assign s_ready       = !rst && (fifo_count != 2'd2);
    assign push          = s_valid && s_ready;
    assign head_grant    = !rst && fifo_nonempty && (!p_wr_en || force_grant);

    wb_skid_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_req    ('{addr: s_addr, data: s_data}),
        .pop         (head_grant),
        .count       (fifo_count),
        .head        (head),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

`ifdef WB_STARVE_GUARD_EN
    logic [STARVE_CNT_W-1:0] starve_cnt;

    assign force_grant = fifo_nonempty && (starve_cnt == STARVE_CNT_W'(STARVE_LIMIT));

    // Count cycles the buffered head waits behind the primary.
    always_ff @(posedge clk) begin
        if (rst || !fifo_nonempty || head_grant) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    // Without the guard the primary always wins; the limit folds to constant false.
    assign force_grant = (STARVE_LIMIT < 0);
`endif

    // Write-port mux: head when granted, else primary; x0 targets are dropped.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        p_stall = 1'b0;
        if (head_grant) begin
            wr_en   = (head.addr != '0);
            wr_addr = head.addr;
            wr_data = head.data;
            p_stall = p_wr_en;
        end else if (!rst && p_wr_en) begin
            wr_en   = (p_wr_addr != '0);
            wr_addr = p_wr_addr;
            wr_data = p_wr_data;
        end
    end

    // Scoreboard bits for registers with a pending buffered write.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid[i]) begin
                busy_mask = busy_mask | reg_onehot(entry_addr[i]);
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized and directed check against a queue model
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_wr_en;
    logic [4:0]  p_wr_addr;
    logic [31:0] p_wr_data;
    logic        s_valid;
    logic [4:0]  s_addr;
    logic [31:0] s_data;
    logic        s_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        p_stall;
    logic [31:0] busy_mask;

    int n_vec = 0;
    int n_err = 0;

    logic [4:0]  qa[$];
    logic [31:0] qd[$];
    int          starve = 0;

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .p_wr_en   (p_wr_en),
        .p_wr_addr (p_wr_addr),
        .p_wr_data (p_wr_data),
        .s_valid   (s_valid),
        .s_addr    (s_addr),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .p_stall   (p_stall),
        .busy_mask (busy_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic pe, input logic [4:0] pa, input logic [31:0] pd,
                        input logic sv, input logic [4:0] sa, input logic [31:0] sd);
        logic        force_g;
        logic        grant;
        logic        exp_rdy;
        logic        exp_wen;
        logic        exp_stall;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic [31:0] em;
        int          sz;
        rst = r; p_wr_en = pe; p_wr_addr = pa; p_wr_data = pd;
        s_valid = sv; s_addr = sa; s_data = sd;
        #1;
        force_g = 1'b0;
`ifdef WB_STARVE_GUARD_EN
        force_g = (qa.size() > 0) && (starve == LIMIT);
`endif
        grant     = !r && (qa.size() > 0) && (!pe || force_g);
        exp_rdy   = !r && (qa.size() < 2);
        exp_stall = grant && pe;
        exp_wen = 1'b0; ea = '0; ed = '0;
        if (grant) begin
            exp_wen = (qa[0] != 0); ea = qa[0]; ed = qd[0];
        end else if (!r && pe) begin
            exp_wen = (pa != 0); ea = pa; ed = pd;
        end
        em = '0;
        foreach (qa[i]) if (qa[i] != 0) em[qa[i]] = 1'b1;
        chk("s_ready", {31'b0, s_ready}, {31'b0, exp_rdy});
        chk("p_stall", {31'b0, p_stall}, {31'b0, exp_stall});
        chk("wr_en", {31'b0, wr_en}, {31'b0, exp_wen});
        if (exp_wen) begin
            chk("wr_addr", {27'b0, wr_addr}, {27'b0, ea});
            chk("wr_data", wr_data, ed);
        end
        if (!r) chk("busy_mask", busy_mask, em);
        @(posedge clk);
        if (r) begin
            qa.delete(); qd.delete(); starve = 0;
        end else begin
            sz = qa.size();
            if (grant) begin
                void'(qa.pop_front()); void'(qd.pop_front());
            end
            if (sv && exp_rdy) begin
                qa.push_back(sa); qd.push_back(sd);
            end
            if (sz == 0 || grant) starve = 0;
            else starve++;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        int bias;
        rst = 1'b1; p_wr_en = 1'b0; p_wr_addr = '0; p_wr_data = '0;
        s_valid = 1'b0; s_addr = '0; s_data = '0;
        @(negedge clk);
        do_reset();
        do_reset();

        // secondary-only single transfer
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEADBEEF);
        idle();
        idle();

        // primary held while three secondary pushes are offered
        do_reset();
        step(1'b0, 1'b1, 5'd3, 32'h11111111, 1'b1, 5'd9, 32'hA0000001);
        step(1'b0, 1'b1, 5'd4, 32'h22222222, 1'b1, 5'd12, 32'hA0000002);
        step(1'b0, 1'b1, 5'd5, 32'h33333333, 1'b1, 5'd15, 32'hA0000003);
        step(1'b0, 1'b1, 5'd6, 32'h44444444, 1'b0, 5'd0, 32'd0);

        // reset with two entries buffered discards them
        do_reset();
        idle();
        idle();

        // x0 secondary write is popped silently
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55AA55AA);
        idle();
        idle();

        // primary x0 write is dropped
        step(1'b0, 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'd0);

        // steady push+pop at occupancy one
        step(1'b0, 1'b1, 5'd1, 32'h0, 1'b1, 5'd20, 32'hC0DE0000);
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(20 + i % 8), 32'hC0DE0000 + i);
        end
        idle();
        idle();

`ifdef WB_STARVE_GUARD_EN
        // starvation guard forces the head through under a held primary
        do_reset();
        step(1'b0, 1'b1, 5'd2, 32'h0BAD0000, 1'b1, 5'd8, 32'hFEEDF00D);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 5'd2, 32'h0BAD0001 + i, 1'b0, 5'd0, 32'd0);
        end
`endif

        // randomized traffic
        bias = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) bias = (c % 300 == 0) ? 20 : ((c % 300 == 100) ? 90 : 50);
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 99) < bias),
                 5'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 1) == 1),
                 5'($urandom_range(0, 31)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
